// File: rtl/issue_scoreboard.sv
// Dual-issue register scoreboard for an in-order pipeline.
// Tracks a 2-bit countdown per architectural register (x1..x31) until its
// result can be forwarded. It decides each cycle whether instr1, instr2 or
// both enter EX1. If only instr1 can go, the block parks in SECOND and waits
// there until instr2's operands clear.
// Optional feature: define BYPASS_EX2_EN to treat a count of 1 as ready,
// because the EX2 result is forwarded.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   id_valid             decode presents an instruction pair
//   id_i1_* / id_i2_*    register addresses, write enable and load flag per slot
//   id_i2_valid          slot 2 holds a real instruction
//   flush                branch redirect, kills the pair in decode
//   issue1, issue2       instruction enters EX1 this cycle (combinational)
//   id_ready             decode may advance at this edge (combinational)
//   stall                id_valid high and id_ready low (combinational)
module issue_scoreboard (
  input  logic       clk,
  input  logic       rstn,
  input  logic       id_valid,
  input  logic [4:0] id_i1_rs1,
  input  logic [4:0] id_i1_rs2,
  input  logic [4:0] id_i1_rd,
  input  logic       id_i1_we,
  input  logic       id_i1_load,
  input  logic [4:0] id_i2_rs1,
  input  logic [4:0] id_i2_rs2,
  input  logic [4:0] id_i2_rd,
  input  logic       id_i2_we,
  input  logic       id_i2_load,
  input  logic       id_i2_valid,
  input  logic       flush,
  output logic       issue1,
  output logic       issue2,
  output logic       id_ready,
  output logic       stall
);

  localparam int unsigned REG_W = 5;
  localparam int unsigned NREG  = 32;
  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] ALU_CNT  = CNT_W'(2);
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(3);
`ifdef BYPASS_EX2_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum logic {PAIR, SECOND} state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0] busy [1:NREG-1];
  logic [NREG-1:0]  rdy_vec;
  logic             i1_ok, i2_ok, conflict;
  logic             wr1, wr2;

  // Per-register operand readiness; x0 is always ready.
  always_comb begin
    rdy_vec    = '0;
    rdy_vec[0] = 1'b1;
    for (int r = 1; r < NREG; r++) begin
      rdy_vec[r] = (busy[r] == '0) || (BYPASS && (busy[r] == CNT_W'(1)));
    end
  end

  assign i1_ok = rdy_vec[id_i1_rs1] && rdy_vec[id_i1_rs2];
  assign i2_ok = rdy_vec[id_i2_rs1] && rdy_vec[id_i2_rs2];

  // instr2 cannot pair with instr1 if it depends on or overwrites instr1's
  // destination register, or if both instructions are loads.
  assign conflict = (id_i1_we && (id_i1_rd != '0) &&
                     ((id_i1_rd == id_i2_rs1) || (id_i1_rd == id_i2_rs2) ||
                      (id_i1_rd == id_i2_rd))) ||
                    (id_i1_load && id_i2_load);

  // Next state and issue decisions.
  always_comb begin
    state_nxt = state;
    issue1    = 1'b0;
    issue2    = 1'b0;
    id_ready  = 1'b1;
    if (!rstn) begin
      id_ready  = 1'b0;
      state_nxt = PAIR;
    end else if (id_valid) begin
      if (flush) begin
        state_nxt = PAIR;
      end else begin
        case (state)
          PAIR: begin
            issue1 = i1_ok;
            issue2 = i1_ok && id_i2_valid && i2_ok && !conflict;
            if (issue1 && id_i2_valid && !issue2) begin
              id_ready  = 1'b0;
              state_nxt = SECOND;
            end else begin
              id_ready = issue1;
            end
          end
          SECOND: begin
            issue2   = i2_ok;
            id_ready = i2_ok;
            if (i2_ok) state_nxt = PAIR;
          end
          default: state_nxt = PAIR;
        endcase
      end
    end
  end

  assign stall = rstn && id_valid && !id_ready;

  assign wr1 = issue1 && id_i1_we && (id_i1_rd != '0);
  assign wr2 = issue2 && id_i2_we && (id_i2_rd != '0);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= PAIR;
    else       state <= state_nxt;
  end

  // Scoreboard counters: a new issue reloads the count; otherwise it counts down.
  always_ff @(posedge clk) begin
    for (int r = 1; r < NREG; r++) begin
      if (!rstn) begin
        busy[r] <= '0;
      end else if (wr2 && (id_i2_rd == REG_W'(r))) begin
        busy[r] <= id_i2_load ? LOAD_CNT : ALU_CNT;
      end else if (wr1 && (id_i1_rd == REG_W'(r))) begin
        busy[r] <= id_i1_load ? LOAD_CNT : ALU_CNT;
      end else if (busy[r] != '0) begin
        busy[r] <= busy[r] - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard. A reference model tracks, for each
// register, the absolute cycle at which its value becomes usable. It also
// tracks whether a split pair is still waiting on its second instruction.
// Each cycle the expected outputs are queued, and a monitor on the falling
// edge compares them with the DUT outputs.
module tb_issue_scoreboard;

`ifdef BYPASS_EX2_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int ALU_LAT  = BYP ? 2 : 3;
  localparam int LOAD_LAT = BYP ? 3 : 4;

  typedef struct {
    bit       v;
    bit [4:0] a_rs1, a_rs2, a_rd;
    bit       a_we, a_ld;
    bit       b_v;
    bit [4:0] b_rs1, b_rs2, b_rd;
    bit       b_we, b_ld;
  } pair_t;

  typedef struct {
    int cyc;
    bit i1, i2, rdy, st;
  } exp_t;

  logic clk, rstn, id_valid, flush;
  logic [4:0] id_i1_rs1, id_i1_rs2, id_i1_rd, id_i2_rs1, id_i2_rs2, id_i2_rd;
  logic id_i1_we, id_i1_load, id_i2_we, id_i2_load, id_i2_valid;
  logic issue1, issue2, id_ready, stall;

  issue_scoreboard dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid),
    .id_i1_rs1(id_i1_rs1), .id_i1_rs2(id_i1_rs2), .id_i1_rd(id_i1_rd),
    .id_i1_we(id_i1_we), .id_i1_load(id_i1_load),
    .id_i2_rs1(id_i2_rs1), .id_i2_rs2(id_i2_rs2), .id_i2_rd(id_i2_rd),
    .id_i2_we(id_i2_we), .id_i2_load(id_i2_load), .id_i2_valid(id_i2_valid),
    .flush(flush), .issue1(issue1), .issue2(issue2),
    .id_ready(id_ready), .stall(stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t  q[$];
  int    tests = 0;
  int    errors = 0;
  int    cyc = 0;
  int    ready_at [32];
  bit    waiting_i2 = 1'b0;
  bit    last_ready = 1'b1;
  pair_t cur;

  function automatic bit mrdy(input bit [4:0] r);
    return (r == 5'd0) || (cyc >= ready_at[r]);
  endfunction

  function automatic pair_t mk(input bit [4:0] ard, ars1, ars2, input bit awe, ald,
                               input bit bv, input bit [4:0] brd, brs1, brs2,
                               input bit bwe, bld);
    pair_t p;
    p.v = 1'b1;
    p.a_rd = ard; p.a_rs1 = ars1; p.a_rs2 = ars2; p.a_we = awe; p.a_ld = ald;
    p.b_v = bv;
    p.b_rd = brd; p.b_rs1 = brs1; p.b_rs2 = brs2; p.b_we = bwe; p.b_ld = bld;
    return p;
  endfunction

  function automatic pair_t rnd_pair();
    pair_t p;
    p.v = ($urandom_range(0, 99) < 85);
    p.a_rs1 = 5'($urandom_range(0, 7)); p.a_rs2 = 5'($urandom_range(0, 7));
    p.a_rd  = 5'($urandom_range(0, 7)); p.a_we = ($urandom_range(0, 9) < 8);
    p.a_ld  = ($urandom_range(0, 9) < 3);
    p.b_v   = ($urandom_range(0, 9) < 8);
    p.b_rs1 = 5'($urandom_range(0, 7)); p.b_rs2 = 5'($urandom_range(0, 7));
    p.b_rd  = 5'($urandom_range(0, 7)); p.b_we = ($urandom_range(0, 9) < 8);
    p.b_ld  = ($urandom_range(0, 9) < 3);
    return p;
  endfunction

  // Drive one cycle, predict the outputs, and advance the model past the edge.
  task automatic step(input bit rst, input bit fl, input pair_t p);
    exp_t e;
    bit   dep, ok1, ok2;
    @(posedge clk);
    #1;
    rstn = !rst; flush = fl; id_valid = p.v;
    id_i1_rs1 = p.a_rs1; id_i1_rs2 = p.a_rs2; id_i1_rd = p.a_rd;
    id_i1_we = p.a_we; id_i1_load = p.a_ld;
    id_i2_valid = p.b_v;
    id_i2_rs1 = p.b_rs1; id_i2_rs2 = p.b_rs2; id_i2_rd = p.b_rd;
    id_i2_we = p.b_we; id_i2_load = p.b_ld;
    e.cyc = cyc; e.i1 = 1'b0; e.i2 = 1'b0; e.rdy = 1'b1;
    if (rst) begin
      e.rdy = 1'b0;
      for (int r = 0; r < 32; r++) ready_at[r] = 0;
      waiting_i2 = 1'b0;
    end else if (p.v && fl) begin
      waiting_i2 = 1'b0;
    end else if (p.v) begin
      ok1 = mrdy(p.a_rs1) && mrdy(p.a_rs2);
      ok2 = mrdy(p.b_rs1) && mrdy(p.b_rs2);
      if (!waiting_i2) begin
        dep = (p.a_we && p.a_rd != 0 &&
               (p.a_rd == p.b_rs1 || p.a_rd == p.b_rs2 || p.a_rd == p.b_rd)) ||
              (p.a_ld && p.b_ld);
        e.i1 = ok1;
        e.i2 = ok1 && p.b_v && ok2 && !dep;
        e.rdy = e.i1 && !(p.b_v && !e.i2);
        waiting_i2 = e.i1 && p.b_v && !e.i2;
      end else begin
        e.i2 = ok2;
        e.rdy = ok2;
        waiting_i2 = !ok2;
      end
    end
    e.st = !rst && p.v && !e.rdy;
    q.push_back(e);
    if (e.i1 && p.a_we && p.a_rd != 0)
      ready_at[p.a_rd] = cyc + (p.a_ld ? LOAD_LAT : ALU_LAT);
    if (e.i2 && p.b_we && p.b_rd != 0)
      ready_at[p.b_rd] = cyc + (p.b_ld ? LOAD_LAT : ALU_LAT);
    last_ready = e.rdy;
    cyc++;
  endtask

  // Present a pair and hold it until the model says decode may advance.
  task automatic present(input pair_t p);
    int n = 0;
    step(1'b0, 1'b0, p);
    while (!last_ready && n < 20) begin
      step(1'b0, 1'b0, p);
      n++;
    end
  endtask

  task automatic cmp(input string name, input int c, input bit act, input bit exp_v);
    tests++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0b expected %0b", name, c, act, exp_v);
    end
  endtask

  // Monitor: compare DUT outputs mid-cycle against the queued predictions.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp("issue1",   e.cyc, issue1,   e.i1);
        cmp("issue2",   e.cyc, issue2,   e.i2);
        cmp("id_ready", e.cyc, id_ready, e.rdy);
        cmp("stall",    e.cyc, stall,    e.st);
      end
    end
  end

  initial begin
    pair_t idle, p;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle.v = 1'b0;
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
    rstn = 1'b0; flush = 1'b0; id_valid = 1'b0;
    step(1'b1, 1'b0, idle);
    step(1'b1, 1'b0, idle);
    step(1'b0, 1'b0, idle);
    // Independent pair, then dependents on x1 and x4.
    present(mk(1, 2, 3, 1, 0, 1, 4, 5, 6, 1, 0));
    present(mk(9, 1, 0, 1, 0, 1, 10, 4, 0, 1, 0));
    // Intra-pair RAW through x5.
    present(mk(5, 0, 0, 1, 0, 1, 8, 5, 0, 1, 0));
    // Load x7, then a dependent on x7.
    present(mk(7, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    present(mk(11, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // Two independent loads are split across two cycles.
    present(mk(12, 13, 14, 1, 1, 1, 15, 16, 17, 1, 1));
    // Flush while waiting on instr2; the x20 counter keeps draining.
    p = mk(20, 0, 0, 1, 0, 1, 21, 20, 0, 1, 0);
    step(1'b0, 1'b0, p);
    step(1'b0, 1'b1, p);
    present(mk(22, 20, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    present(mk(23, 20, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // Reset while x3 is loading clears the counter; a dependent issues at once.
    present(mk(3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    step(1'b1, 1'b0, idle);
    present(mk(24, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0));
    // Reset while waiting on instr2 abandons the pending instruction.
    p = mk(25, 0, 0, 1, 0, 1, 26, 25, 0, 1, 0);
    step(1'b0, 1'b0, p);
    step(1'b1, 1'b0, p);
    present(mk(27, 25, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    // Randomized traffic: decode holds the pair while id_ready is low.
    cur = rnd_pair();
    for (int i = 0; i < 3000; i++) begin
      if (last_ready) cur = rnd_pair();
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 5, cur);
    end
    @(negedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

Interface
REQ-001 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-002 Ports, in order:
- clk  in  1  clock, rising edge
- rstn  in  1  synchronous active-low reset
- id_valid  in  1  decode presents an instruction pair
- id_i1_rs1, id_i1_rs2, id_i1_rd  in  5 each  instr1 register addresses
- id_i1_we  in  1  instr1 writes rd
- id_i1_load  in  1  instr1 is a load
- id_i2_rs1, id_i2_rs2, id_i2_rd, id_i2_we, id_i2_load  in  5/5/5/1/1  same fields for instr2
- id_i2_valid  in  1  slot 2 holds a real instruction
- flush  in  1  branch redirect; kills the pair in decode
- issue1  out  1  instr1 enters EX1 this cycle
- issue2  out  1  instr2 enters EX1 this cycle
- id_ready  out  1  decode may advance to the next pair at this edge
- stall  out  1  id_valid high and id_ready low

Function
REQ-003 The block SHALL hold scoreboard counters busy[1..31], 2 bits each; x0 SHALL never be busy.
REQ-004 Each cycle, any nonzero busy[r] not written by an issue SHALL decrement by 1.
REQ-005 On issue of an instruction with we=1 and rd!=0: busy[rd] SHALL load 3 for a load, 2 otherwise; the load SHALL override the decrement in the same cycle.
REQ-006 Operand rs is ready when rs=0, or busy[rs]=0, or (busy[rs]=1 and BYPASS_EX2_EN defined).
REQ-007 FSM states: PAIR, SECOND; reset state PAIR.
REQ-008 In PAIR: issue1 = id_valid and !flush and both instr1 operands ready.
REQ-009 In PAIR: issue2 = issue1 and id_i2_valid and both instr2 operands ready and no pairing conflict.
REQ-010 Pairing conflict: (id_i1_we, id_i1_rd!=0, id_i1_rd equals id_i2_rs1 or id_i2_rs2 or id_i2_rd) or (id_i1_load and id_i2_load).
REQ-011 In PAIR, issue1=1 and issue2=0 with id_i2_valid=1 SHALL move to SECOND with id_ready=0; otherwise id_ready = issue1.
REQ-012 In SECOND: issue1=0; issue2 = !flush and both instr2 operands ready per REQ-006, including instr1's rd now in the scoreboard; on issue2, id_ready=1 and return to PAIR.
REQ-013 Decode SHALL hold the pair stable while id_ready=0; the block reads the id_* inputs combinationally every cycle.
REQ-014 flush SHALL force issue1=issue2=0 and id_ready=1, and return the FSM to PAIR next edge. Scoreboard counting SHALL continue, because older instructions still commit.
REQ-015 issue1, issue2, id_ready and stall SHALL be combinational from the FSM state, scoreboard and inputs: zero-cycle latency.
REQ-016 With id_valid=0: issue1=issue2=0, id_ready=1, stall=0, and the FSM state SHALL be unchanged.

Reset
REQ-017 With rstn=0 at a clock edge: all busy counters SHALL be cleared to 0 and the FSM SHALL enter PAIR.
REQ-018 While rstn=0: issue1=issue2=stall=0 and id_ready=0.
REQ-019 Reset asserted while in SECOND SHALL abandon the pending instr2 with no issue.

Configuration
REQ-020 Macro BYPASS_EX2_EN: when defined, a count of 1 counts as ready, because the EX2-stage result is forwarded. An ALU-to-dependent gap is then 1 bubble; a load-to-dependent gap is 2 bubbles.
REQ-021 Without BYPASS_EX2_EN: only a count of 0 counts as ready, forwarding from the commit stage only. An ALU gap is then 2 bubbles; a load gap is 3 bubbles.

Verification
REQ-022 Independent pair (i1: x1<-x2,x3; i2: x4<-x5,x6), scoreboard clear -> issue1=issue2=id_ready=1 in the same cycle; busy[1]=busy[4]=2 after the edge.
REQ-023 Intra-pair RAW (i1 rd=x5; i2 rs1=x5) -> cycle 0: issue1=1, issue2=0, stall=1. SECOND state: issue2 held until busy[5] is ready, i.e. 1 cycle with BYPASS_EX2_EN or 2 cycles without; then id_ready=1.
REQ-024 Load x7 then next pair i1 rs1=x7 -> stall=1 for 2 cycles (BYPASS_EX2_EN) or 3 cycles (without); then issue1=1.
REQ-025 Two loads in one pair, no register overlap -> split issue: issue1 in cycle 0, issue2 in cycle 1, id_ready=1 in cycle 1.
REQ-026 Flush in SECOND -> issue2=0, id_ready=1, PAIR next cycle; a busy[r]=2 entry SHALL still read 1 after the edge.
REQ-027 rstn=0 for one edge while busy[3]=3 -> busy[3]=0; a dependent on x3 presented next SHALL issue immediately.
